// File: rtl/seg7_scan_driver_if.sv
// Bundle of signals between board-level logic (master) and the
// seven-segment scan driver (slave).
//   value      packed nibbles, digit i = value[4i+3:4i]
//   load       capture value/dp_in into the driver's shadow registers
//   dp_in      per-digit decimal point, 1 = lit
//   en_mask    per-digit enable, sampled live
//   blank_lz   blank leading zeros, sampled live
//   mode_bcd   1 = nibbles above 9 show a dash
//   seg        segments {g,f,e,d,c,b,a}
//   dp_out     decimal point of the active digit
//   an         one-hot digit select
//   frame_tick one-cycle pulse at scan wrap
interface seg7_scan_driver_if #(
    parameter int DIGITS = 8
);
    logic [4*DIGITS-1:0] value;
    logic                load;
    logic [DIGITS-1:0]   dp_in;
    logic [DIGITS-1:0]   en_mask;
    logic                blank_lz;
    logic                mode_bcd;
    logic [6:0]          seg;
    logic                dp_out;
    logic [DIGITS-1:0]   an;
    logic                frame_tick;

    modport master (
        output value, load, dp_in, en_mask, blank_lz, mode_bcd,
        input  seg, dp_out, an, frame_tick
    );

    modport slave (
        input  value, load, dp_in, en_mask, blank_lz, mode_bcd,
        output seg, dp_out, an, frame_tick
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Multi-digit seven-segment scan driver. Captures a nibble vector into a
// shadow register and time-multiplexes it across DIGITS digits, with
// per-digit enable, decimal points, leading-zero blanking, BCD/hex mode and
// one cycle of dead time at the start of every digit slot.
// Ports:
//   clk  system clock
//   rst  synchronous reset, active-high
//   bus  seg7_scan_driver_if slave modport (DIGITS must match)
// All outputs are registered: they reflect idx/prescaler/shadow/live
// controls of the previous cycle.
module seg7_scan_driver #(
    parameter int DIGITS     = 8,
    parameter int DIV        = 1000,
    parameter int ACTIVE_LOW = 1
) (
    input logic               clk,
    input logic               rst,
    seg7_scan_driver_if.slave bus
);
    localparam int                IDXW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int                PW       = $clog2(DIV);
    localparam logic [PW-1:0]     PS_LAST  = PW'(DIV - 1);
    localparam logic [IDXW-1:0]   IDX_LAST = IDXW'(DIGITS - 1);
    // Internal logic is active-low; INV flips all pins for active-high boards.
    localparam logic              INV      = (ACTIVE_LOW == 0);

    logic [4*DIGITS-1:0] shadow;
    logic [DIGITS-1:0]   shadow_dp;
    logic [IDXW-1:0]     idx;
    logic [PW-1:0]       prescaler;

    logic [DIGITS-1:0]   zero_from;
    logic [3:0]          nib;
    logic                cur_en;
    logic                cur_dp;
    logic                cur_zero;
    logic                zero_run;
    logic                suppress;
    logic [6:0]          seg_al;
    logic [6:0]          seg_next;
    logic                dp_next;
    logic [DIGITS-1:0]   an_next;

    function automatic logic [6:0] decode_al(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    always_comb begin
        zero_from = '0;
        zero_run  = 1'b1;
        nib       = 4'h0;
        cur_en    = 1'b0;
        cur_dp    = 1'b0;
        cur_zero  = 1'b0;
        // zero_from[i]: nibbles i..DIGITS-1 of the shadow are all zero.
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run     = zero_run & (shadow[4*i +: 4] == 4'h0);
            zero_from[i] = zero_run;
        end
        for (int i = 0; i < DIGITS; i++) begin
            if (IDXW'(i) == idx) begin
                nib      = shadow[4*i +: 4];
                cur_en   = bus.en_mask[i];
                cur_dp   = shadow_dp[i];
                cur_zero = zero_from[i];
            end
        end
        // Digit 0 is never blanked by leading-zero suppression.
        suppress = !cur_en || (bus.blank_lz && (idx != '0) && cur_zero);
        seg_al   = (bus.mode_bcd && (nib > 4'd9)) ? 7'b0111111 : decode_al(nib);
        seg_next = suppress ? 7'b1111111 : seg_al;
        dp_next  = suppress ? 1'b1 : !cur_dp;
        an_next  = '1;
        // Slot dead time: anodes stay off while prescaler is 0.
        if ((prescaler != '0) && !suppress) begin
            an_next[idx] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow         <= '0;
            shadow_dp      <= '0;
            idx            <= '0;
            prescaler      <= '0;
            bus.seg        <= {7{!INV}};
            bus.dp_out     <= !INV;
            bus.an         <= {DIGITS{!INV}};
            bus.frame_tick <= 1'b0;
        end else begin
            if (bus.load) begin
                shadow    <= bus.value;
                shadow_dp <= bus.dp_in;
            end
            if (prescaler == PS_LAST) begin
                prescaler <= '0;
                idx       <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                prescaler <= prescaler + 1'b1;
            end
            bus.frame_tick <= (prescaler == PS_LAST) && (idx == IDX_LAST);
            bus.seg        <= seg_next ^ {7{INV}};
            bus.dp_out     <= dp_next ^ INV;
            bus.an         <= an_next ^ {DIGITS{INV}};
        end
    end
endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Parametrised multi-digit seven-segment driver; successor to the single-digit hex decoder.
- Captures a packed nibble vector into a shadow register and time-multiplexes it across DIGITS common-anode/cathode digits.
- Adds per-digit enable, decimal points, leading-zero blanking, a BCD/hex mode and anti-ghosting dead time.
- Sits between board-level logic and the seg/anode pins of the display bank.

Parameters:
- DIGITS, 8, number of digits scanned; legal range 1..16.
- DIV, 1000, clocks per digit slot; legal minimum 2.
- ACTIVE_LOW, 1, 1 = seg/dp/an driven active-low; 0 = all three inverted to active-high.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- value  in  4*DIGITS  packed nibbles; digit i = value[4i+3:4i]; digit 0 is rightmost/least significant
- load  in  1  capture value and dp_in into the shadow registers
- dp_in  in  DIGITS  decimal point per digit, 1 = lit
- en_mask  in  DIGITS  1 = digit enabled; sampled live, not shadowed
- blank_lz  in  1  1 = blank leading zeros; sampled live
- mode_bcd  in  1  1 = nibbles >9 display "-"; 0 = hex 0-F; sampled live
- seg  out  7  segments {g,f,e,d,c,b,a}; bit 0 = a
- dp_out  out  1  decimal point of the active digit
- an  out  DIGITS  digit select, one-hot (polarity per ACTIVE_LOW)
- frame_tick  out  1  one-cycle pulse when the scan wraps from digit DIGITS-1 to 0

Behaviour:
Reset:
- Shadow value = 0, shadow dp = 0, idx = 0, prescaler = 0.
- Outputs: seg = all off, dp_out = off, an = all off, frame_tick = 0. With ACTIVE_LOW=1 that is seg = 7'b1111111, dp_out = 1, an = all ones.
- load asserted together with rst is ignored.

Shadow capture:
- On a clk edge with load=1, shadow <= value and shadow dp <= dp_in.
- Display uses the shadow only, so there is no mid-frame tearing from value changes.

Scan timing:
- prescaler counts 0..DIV-1 and wraps.
- When prescaler == DIV-1, idx advances; DIGITS-1 wraps to 0.
- frame_tick = 1 for exactly the cycle in which idx changes DIGITS-1 -> 0; otherwise 0.
- With DIGITS=1, frame_tick pulses once per slot.

Outputs:
- Registered, computed from (idx, prescaler, shadow, live controls) of the previous cycle. Latency is 1 clk.

Dead time:
- When prescaler == 0, an = all off (anti-ghosting).
- For prescaler 1..DIV-1, an has exactly bit idx active, unless that digit is suppressed.

Suppression (digit i):
- Suppressed if en_mask[i] == 0, or if all of the following hold: blank_lz == 1, i != 0, and shadow nibbles i..DIGITS-1 are all zero.
- Digit 0 is never blanked by blank_lz.
- While suppressed: an all off, seg all off, dp_out off.

Decode (active-low form, {g..a}):
- 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
- 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000
- 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011
- C = 1000110, d = 0100001, E = 0000110, F = 0001110
- If mode_bcd == 1 and the nibble is >9: seg = 0111111 (only g lit).
- ACTIVE_LOW == 0 inverts seg, dp_out and an bitwise.

Simultaneous events:
- load coinciding with a slot advance: the new shadow is used from the next registered output.
- rst mid-frame returns idx to 0 and restarts the prescaler immediately; outputs are off on the following cycle.

Test Plan:
- DIGITS=4, DIV=4, rst 2 cycles -> seg=7'b1111111, an=4'b1111, dp_out=1, frame_tick=0. After release, an sequence per slot is 1111, 1110, 1110, 1110, then 1111, 1101, ... frame_tick pulses every 16 clks.
- load value=16'h8A10, mode_bcd=0, dp_in=4'b0100, en_mask=1111 -> digit0 seg=1000000, digit1 seg=1111001, digit2 seg=0001000 with dp_out=0, digit3 seg=0000000.
- value=16'h00F0, blank_lz=1 -> digits 3 and 2 an stay off; digit1 seg=0001110; digit0 shows 1000000. value=0 -> only digit0 lit with 1000000.
- mode_bcd=1, value=16'h9C0B -> digit0 and digit2 seg=0111111, digit3 seg=0010000, digit1 seg=1000000. en_mask=4'b1011 -> digit2 never selected.
- Change value without load mid-frame -> display unchanged. Assert load at prescaler==DIV-1 -> new data appears in the next slot. Assert rst mid-slot -> outputs off next cycle, scan restarts at digit 0.
- ACTIVE_LOW=0, DIGITS=1, DIV=2 -> an alternates 0,1; digit "8" gives seg=7'b1111111; frame_tick pulses every 2 clks.
